noc_inject_buffer: RTL and testbench



---
 rtl/noc_pkg.sv | 41 ++++
 rtl/noc_sync_fifo.sv | 58 +++++
 rtl/noc_inject_buffer.sv | 123 ++++++++++++
 tb/tb_noc_inject_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit/ctrl widths, control codes, output port codes,
// plus the XY route and Hamming syndrome helpers used at injection.
package noc_pkg;

   localparam int FLIT_W = 11;
   localparam int CTRL_W = 2;

   typedef enum logic [2:0] {
      PORT_LOCAL = 3'd0,
      PORT_EAST  = 3'd1,
      PORT_WEST  = 3'd2,
      PORT_NORTH = 3'd3,
      PORT_SOUTH = 3'd4
   } port_e;

   localparam logic [CTRL_W-1:0] CTRL_DROP0 = 2'd0;
   localparam logic [CTRL_W-1:0] CTRL_CFG   = 2'd1;
   localparam logic [CTRL_W-1:0] CTRL_DATA  = 2'd2;
   localparam logic [CTRL_W-1:0] CTRL_DROP3 = 2'd3;

   // Dimension-ordered routing: resolve X completely before looking at Y.
   function automatic port_e xy_route(input logic [1:0] dx, input logic [1:0] dy,
                                      input logic [1:0] lx, input logic [1:0] ly);
      port_e p;
      if (dx > lx)      p = PORT_EAST;
      else if (dx < lx) p = PORT_WEST;
      else if (dy > ly) p = PORT_NORTH;
      else if (dy < ly) p = PORT_SOUTH;
      else              p = PORT_LOCAL;
      return p;
   endfunction

   function automatic logic [2:0] hamming_syndrome(input logic [6:0] raw);
      logic [2:0] s;
      s[0] = raw[0] ^ raw[2] ^ raw[4] ^ raw[6];
      s[1] = raw[1] ^ raw[2] ^ raw[5] ^ raw[6];
      s[2] = raw[3] ^ raw[4] ^ raw[5] ^ raw[6];
      return s;
   endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with power-of-two depth; head entry is presented
// combinationally on rd_data. Overflowing pushes and empty pops are ignored.
module noc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers are PTR_W bits wide, so increments wrap modulo DEPTH.
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; count gates validity, and leaving the array
   // unreset lets it map onto plain RAM/flops without a reset tree.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/noc_inject_buffer.sv
// NoC injection buffer: decodes core ctrl tags, routes data flits (XY) at
// enqueue and queues them for the router. Optional PARITY_CHECK_EN adds a Hamming check.
module noc_inject_buffer
   import noc_pkg::*;
#(
   parameter int          DEPTH   = 4,
   parameter logic [1:0]  LOCAL_X = 2'd1,
   parameter logic [1:0]  LOCAL_Y = 2'd2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FLIT_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FLIT_W-1:0] out_data,
   output logic [2:0]        out_port,
   output logic              out_err,
   output logic [7:0]        drop_cnt,
   output logic [7:0]        err_cnt
);

   typedef struct packed {
`ifdef PARITY_CHECK_EN
      logic                err;
`endif
      port_e               port;
      logic [FLIT_W-1:0]   data;
   } entry_t;

   logic [1:0]  loc_x;
   logic [1:0]  loc_y;
   logic        accept;
   logic        is_data;
   logic        is_cfg;
   logic        is_drop;
   logic        fifo_full;
   logic        fifo_empty;
   entry_t      wr_entry;
   entry_t      head;
   logic [7:0]  drop_q;

   assign in_ready = !fifo_full;
   assign accept   = in_valid && in_ready;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      is_data = 1'b0;
      is_cfg  = 1'b0;
      is_drop = 1'b0;
      if (accept) begin
         case (in_ctrl)
            CTRL_DATA: is_data = 1'b1;
            CTRL_CFG:  is_cfg  = 1'b1;
            default:   is_drop = 1'b1;
         endcase
      end
   end

   always_comb begin
      wr_entry      = '0;
      wr_entry.data = in_data;
      wr_entry.port = xy_route(in_data[3:2], in_data[1:0], loc_x, loc_y);
`ifdef PARITY_CHECK_EN
      wr_entry.err  = |hamming_syndrome(in_data[10:4]);
`endif
   end

   noc_sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (is_data),
      .pop     (out_valid && out_ready),
      .wr_data (wr_entry),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         loc_x  <= LOCAL_X;
         loc_y  <= LOCAL_Y;
         drop_q <= '0;
      end else begin
         if (is_cfg) begin
            loc_x <= in_data[3:2];
            loc_y <= in_data[1:0];
         end
         if (is_drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
   end

   assign drop_cnt  = drop_q;
   assign out_valid = !fifo_empty;
   // Unwritten storage is never exposed: outputs read zero while empty.
   assign out_data  = out_valid ? head.data : '0;
   assign out_port  = out_valid ? head.port : PORT_LOCAL;

`ifdef PARITY_CHECK_EN
   logic [7:0] err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= '0;
      end else if (is_data && wr_entry.err && err_q != 8'hFF) begin
         err_q <= err_q + 8'd1;
      end
   end

   assign err_cnt = err_q;
   assign out_err = out_valid && head.err;
`else
   assign err_cnt = '0;
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_inject_buffer.sv
// Directed bench for noc_inject_buffer; expectations follow PARITY_CHECK_EN
// when the same macro is defined for the build.
module tb_noc_inject_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_data;
   logic [1:0]  in_ctrl;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_data;
   logic [2:0]  out_port;
   logic        out_err;
   logic [7:0]  drop_cnt;
   logic [7:0]  err_cnt;

   int total  = 0;
   int passed = 0;

   noc_inject_buffer #(.DEPTH(4), .LOCAL_X(2'd1), .LOCAL_Y(2'd2)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_port  (out_port),
      .out_err   (out_err),
      .drop_cnt  (drop_cnt),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Offer one flit, waiting (bounded) for in_ready; returns 1 time unit after the transfer edge.
   task automatic send(input logic [10:0] d, input logic [1:0] c);
      int waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_ctrl  = c;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (!in_ready) $display("FAIL send_wait: in_ready=%b required 1 for flit %h", in_ready, d);
      else passed++;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic pop_one(output logic [10:0] d, output logic [2:0] p, output logic e);
      int waited = 0;
      @(negedge clk);
      while (!out_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (!out_valid) $display("FAIL pop_wait: out_valid=%b required 1", out_valid);
      else passed++;
      d = out_data;
      p = out_port;
      e = out_err;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
      total++; if (out_data !== 11'h000) $display("FAIL rst_out_data: got %h want 000", out_data); else passed++;
      total++; if (out_port !== 3'd0) $display("FAIL rst_out_port: got %0d want 0", out_port); else passed++;
      total++; if (out_err !== 1'b0) $display("FAIL rst_out_err: got %b want 0", out_err); else passed++;
      total++; if (drop_cnt !== 8'h00) $display("FAIL rst_drop_cnt: got %h want 00", drop_cnt); else passed++;
      total++; if (err_cnt !== 8'h00) $display("FAIL rst_err_cnt: got %h want 00", err_cnt); else passed++;
   endtask

   task automatic test_basic();
      logic [10:0] d; logic [2:0] p; logic e;
      send(11'h5A3, 2'd2);
      total++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else passed++;
      total++; if (out_data !== 11'h5A3) $display("FAIL basic_data: got %h want 5a3", out_data); else passed++;
      total++; if (out_port !== 3'd2) $display("FAIL basic_port: got %0d want 2", out_port); else passed++;
      pop_one(d, p, e);
      total++; if (out_valid !== 1'b0) $display("FAIL basic_empty: got %b want 0", out_valid); else passed++;
   endtask

   task automatic test_full();
      logic [10:0] d; logic [2:0] p; logic e;
      logic [10:0] exp_d [3] = '{11'h30B, 11'h40F, 11'h502};
      send(11'h103, 2'd2);
      send(11'h207, 2'd2);
      send(11'h30B, 2'd2);
      send(11'h40F, 2'd2);
      total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", in_ready); else passed++;
      @(negedge clk);
      in_valid = 1'b1; in_data = 11'h502; in_ctrl = 2'd2;
      repeat (2) @(negedge clk);
      total++; if (in_ready !== 1'b0) $display("FAIL full_hold_ready: got %b want 0", in_ready); else passed++;
      total++; if (out_data !== 11'h103) $display("FAIL full_stable_data: got %h want 103", out_data); else passed++;
      total++; if (out_port !== 3'd2) $display("FAIL full_stable_port: got %0d want 2", out_port); else passed++;
      out_ready = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) $display("FAIL full_after_pop_ready: got %b want 1", in_ready); else passed++;
      total++; if (out_data !== 11'h207) $display("FAIL full_order1: got %h want 207", out_data); else passed++;
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pop_one(d, p, e);
         total++; if (d !== exp_d[i]) $display("FAIL full_order%0d: got %h want %h", i + 2, d, exp_d[i]); else passed++;
      end
      total++; if (out_valid !== 1'b0) $display("FAIL full_drained: got %b want 0", out_valid); else passed++;
   endtask

   task automatic test_config_route();
      logic [10:0] d; logic [2:0] p; logic e;
      logic [2:0] exp_p [3] = '{3'd1, 3'd3, 3'd4};
      send(11'h00F, 2'd1);
      total++; if (out_valid !== 1'b0) $display("FAIL cfg_not_queued: out_valid got %b want 0", out_valid); else passed++;
      send(11'h00F, 2'd2);
      send(11'h003, 2'd2);
      pop_one(d, p, e);
      total++; if (p !== 3'd0) $display("FAIL cfg_route_local: got %0d want 0", p); else passed++;
      pop_one(d, p, e);
      total++; if (p !== 3'd2) $display("FAIL cfg_route_west: got %0d want 2", p); else passed++;
      // Local (1,1); queue east/north/south, then move local before popping.
      send(11'h005, 2'd1);
      send(11'h00D, 2'd2);
      send(11'h006, 2'd2);
      send(11'h004, 2'd2);
      send(11'h00F, 2'd1);
      for (int i = 0; i < 3; i++) begin
         pop_one(d, p, e);
         total++; if (p !== exp_p[i]) $display("FAIL route_stored%0d: got %0d want %0d", i, p, exp_p[i]); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] prev;
      logic [10:0] d;
      do_reset();
      @(negedge clk);
      out_ready = 1'b1;
      in_ctrl   = 2'd2;
      prev      = '0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            total++; if (out_data !== prev || out_valid !== 1'b1 || in_ready !== 1'b1)
               $display("FAIL b2b_%0d: data %h valid %b ready %b want %h 1 1", i, out_data, out_valid, in_ready, prev);
            else passed++;
         end
         d        = {7'(i * 5 + 3), 4'b0110};
         in_valid = 1'b1;
         in_data  = d;
         prev     = d;
         @(negedge clk);
      end
      in_valid = 1'b0;
      total++; if (out_data !== prev) $display("FAIL b2b_last: got %h want %h", out_data, prev); else passed++;
      @(posedge clk);
      #1 out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", out_valid); else passed++;
   endtask

   task automatic test_drop();
      do_reset();
      send(11'h123, 2'd0);
      send(11'h456, 2'd3);
      total++; if (out_valid !== 1'b0) $display("FAIL drop_not_queued: out_valid got %b want 0", out_valid); else passed++;
      total++; if (drop_cnt !== 8'd2) $display("FAIL drop_cnt2: got %0d want 2", drop_cnt); else passed++;
      @(negedge clk);
      in_valid = 1'b1; in_ctrl = 2'd0; in_data = 11'h7FF;
      repeat (250) @(posedge clk);
      #1;
      total++; if (drop_cnt !== 8'd252) $display("FAIL drop_cnt252: got %0d want 252", drop_cnt); else passed++;
      repeat (48) @(posedge clk);
      #1 in_valid = 1'b0;
      total++; if (drop_cnt !== 8'hFF) $display("FAIL drop_saturate: got %h want ff", drop_cnt); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL drop_never_out: out_valid got %b want 0", out_valid); else passed++;
   endtask

   task automatic test_parity();
      logic [10:0] d; logic [2:0] p; logic e;
      logic       exp_e;
      logic [7:0] exp_cnt;
`ifdef PARITY_CHECK_EN
      exp_e = 1'b1; exp_cnt = 8'd1;
`else
      exp_e = 1'b0; exp_cnt = 8'd0;
`endif
      do_reset();
      send(11'h000, 2'd2);
      pop_one(d, p, e);
      total++; if (e !== 1'b0) $display("FAIL parity_clean: out_err got %b want 0", e); else passed++;
      send(11'h040, 2'd2);
      total++; if (out_err !== exp_e) $display("FAIL parity_bad: out_err got %b want %b", out_err, exp_e); else passed++;
      total++; if (err_cnt !== exp_cnt) $display("FAIL parity_cnt: err_cnt got %0d want %0d", err_cnt, exp_cnt); else passed++;
      pop_one(d, p, e);
   endtask

   task automatic test_reset_mid();
      logic [10:0] d; logic [2:0] p; logic e;
      do_reset();
      send(11'h000, 2'd1);
      send(11'h111, 2'd0);
      send(11'h040, 2'd2);
      send(11'h123, 2'd2);
      send(11'h234, 2'd2);
      // Hold a drop flit and a pop request across the reset edge.
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b1; in_ctrl = 2'd0; out_ready = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready); else passed++;
      total++; if (drop_cnt !== 8'd0) $display("FAIL mid_drop_cnt: got %0d want 0", drop_cnt); else passed++;
      total++; if (err_cnt !== 8'd0) $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); else passed++;
      send(11'h006, 2'd2);
      pop_one(d, p, e);
      total++; if (p !== 3'd0) $display("FAIL mid_local_restored: port got %0d want 0", p); else passed++;
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_full();
      test_config_route();
      test_back_to_back();
      test_drop();
      test_parity();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
